fp_addsub_ctrl: RTL

- Multi-cycle sequencer for IEEE-754 single-precision add/subtract.
- Built around one shared 24-bit mantissa ALU instance (BigAlu_CLA), which has no internal state.
- Sequences unpack, exponent alignment, the mantissa add/sub, iterative normalisation and pack.
- Sits between the operand source and the result consumer. Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_addsub_ctrl_alu.sv | 36 +++
 rtl/fp_addsub_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/sub sequencer.
package fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADD,
    NORM,
    PACK,
    DONE
  } state_t;

endpackage

// File: rtl/fp_addsub_ctrl_alu.sv
// Stateless mantissa adder/subtractor with carry-lookahead style generate/propagate.
// Output carries one extra bit so an unsigned add can overflow into out[W].
module BigAlu_CLA #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sign_a,
  input  logic         sign_b,
  input  logic         symbol,
  output logic [W:0]   out
);

  logic       sub;
  logic [W:0] x;
  logic [W:0] y;
  logic [W:0] g;
  logic [W:0] p;
  logic [W:0] c;

  // Signs of differing polarity, or an explicit subtract, turn the op into a - b.
  always_comb begin
    sub  = sign_a ^ sign_b ^ symbol;
    x    = {1'b0, a};
    y    = sub ? ~{1'b0, b} : {1'b0, b};
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = sub;
    for (int unsigned i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    out = p ^ c;
  end

endmodule

// File: rtl/fp_addsub_ctrl.sv
// Multi-cycle IEEE-754 single add/sub sequencer around one shared mantissa ALU.
// Truncating arithmetic, denormal inputs flushed to zero, one operation in flight.
module fp_addsub_ctrl #(
  parameter int unsigned EXP_W = fp_pkg::EXP_W,
  parameter int unsigned MAN_W = fp_pkg::MAN_W,
  parameter int unsigned BIAS  = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 symbol,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 busy
);

  import fp_pkg::*;

  localparam int unsigned      W         = EXP_W + MAN_W + 1;
  localparam int unsigned      MW        = MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_TOP   = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MW);
  localparam logic [W-1:0]     NAN_PAT   = W'(QNAN);
  localparam logic [W-1:0]     INF_PAT   = W'(POS_INF);

  if (BIAS != (2 ** (EXP_W - 1)) - 1) begin : g_bias_chk
    $error("fp_addsub_ctrl: BIAS inconsistent with EXP_W");
  end

  state_t state;
  state_t state_nxt;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sym_q;

  logic             sgn_a;
  logic             sgn_b;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MW-1:0]    man_a;
  logic [MW-1:0]    man_b;

  logic [EXP_W-1:0] u_exp_a;
  logic [EXP_W-1:0] u_exp_b;
  logic [MAN_W-1:0] u_frac_a;
  logic [MAN_W-1:0] u_frac_b;
  logic             u_sgn_b;
  logic             nan_a;
  logic             nan_b;
  logic             inf_a;
  logic             inf_b;
  logic             special;
  logic [W-1:0]     special_res;

  logic             a_larger;
  logic             sgn_l;
  logic             sgn_s;
  logic [EXP_W-1:0] exp_l;
  logic [EXP_W-1:0] exp_s;
  logic [EXP_W-1:0] shift_d;
  logic [MW-1:0]    man_l;
  logic [MW-1:0]    man_s;
  logic [MW-1:0]    man_s_sh;

  logic [MW-1:0]    alu_a;
  logic [MW-1:0]    alu_b;
  logic             alu_sign_a;
  logic             alu_sign_b;
  logic             alu_sym;
  logic [MW:0]      alu_out;

  logic [MW:0]      w_man;
  logic [EXP_W-1:0] w_exp;
  logic             w_sgn;

  BigAlu_CLA #(.W(MW)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sign_a (alu_sign_a),
    .sign_b (alu_sign_b),
    .symbol (alu_sym),
    .out    (alu_out)
  );

  always_comb begin
    u_exp_a  = a_q[W-2 -: EXP_W];
    u_exp_b  = b_q[W-2 -: EXP_W];
    u_frac_a = a_q[MAN_W-1:0];
    u_frac_b = b_q[MAN_W-1:0];
    u_sgn_b  = b_q[W-1] ^ sym_q;
    nan_a    = (u_exp_a == EXP_TOP) && (u_frac_a != '0);
    nan_b    = (u_exp_b == EXP_TOP) && (u_frac_b != '0);
    inf_a    = (u_exp_a == EXP_TOP) && (u_frac_a == '0);
    inf_b    = (u_exp_b == EXP_TOP) && (u_frac_b == '0);
    special  = (u_exp_a == EXP_TOP) || (u_exp_b == EXP_TOP);
    if (nan_a || nan_b || (inf_a && inf_b && (a_q[W-1] != u_sgn_b))) begin
      special_res = NAN_PAT;
    end else if (inf_a) begin
      special_res = {a_q[W-1], INF_PAT[W-2:0]};
    end else begin
      special_res = {u_sgn_b, INF_PAT[W-2:0]};
    end
  end

  // Larger magnitude is decided on exponent first, then mantissa, so a-b never goes negative.
  always_comb begin
    a_larger = {exp_a, man_a} >= {exp_b, man_b};
    sgn_l    = a_larger ? sgn_a : sgn_b;
    sgn_s    = a_larger ? sgn_b : sgn_a;
    exp_l    = a_larger ? exp_a : exp_b;
    exp_s    = a_larger ? exp_b : exp_a;
    man_l    = a_larger ? man_a : man_b;
    man_s    = a_larger ? man_b : man_a;
    shift_d  = exp_l - exp_s;
    man_s_sh = (shift_d >= SHIFT_LIM) ? '0 : (man_s >> shift_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = UNPACK;
      end
      UNPACK: state_nxt = special ? PACK : ALIGN;
      ALIGN:  state_nxt = ADD;
      ADD:    state_nxt = (alu_out == '0) ? PACK : NORM;
      NORM: begin
        if (w_man[MW]) begin
          if (w_exp == EXP_TOP - EXP_ONE) state_nxt = PACK;
        end else if (!w_man[MW-1]) begin
          if (w_exp <= EXP_ONE) state_nxt = PACK;
        end else begin
          state_nxt = PACK;
        end
      end
      PACK: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Special-case results are preloaded into the working registers so PACK stays uniform.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sym_q      <= 1'b0;
      sgn_a      <= 1'b0;
      sgn_b      <= 1'b0;
      exp_a      <= '0;
      exp_b      <= '0;
      man_a      <= '0;
      man_b      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sign_a <= 1'b0;
      alu_sign_b <= 1'b0;
      alu_sym    <= 1'b0;
      w_man      <= '0;
      w_exp      <= '0;
      w_sgn      <= 1'b0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sym_q <= symbol;
          end
        end
        UNPACK: begin
          sgn_a <= a_q[W-1];
          sgn_b <= u_sgn_b;
          exp_a <= u_exp_a;
          exp_b <= u_exp_b;
          man_a <= (u_exp_a != '0) ? {1'b1, u_frac_a} : '0;
          man_b <= (u_exp_b != '0) ? {1'b1, u_frac_b} : '0;
          w_sgn <= special_res[W-1];
          w_exp <= special_res[W-2 -: EXP_W];
          w_man <= {2'b00, special_res[MAN_W-1:0]};
        end
        ALIGN: begin
          alu_a      <= man_l;
          alu_b      <= man_s_sh;
          alu_sign_a <= 1'b0;
          alu_sign_b <= 1'b0;
          alu_sym    <= (sgn_l != sgn_s);
          w_exp      <= exp_l;
          w_sgn      <= sgn_l;
        end
        ADD: begin
          w_man <= alu_out;
          if (alu_out == '0) begin
            w_exp <= '0;
            if (alu_sym) w_sgn <= 1'b0;
          end
        end
        NORM: begin
          if (w_man[MW]) begin
            if (w_exp == EXP_TOP - EXP_ONE) begin
              w_man <= '0;
              w_exp <= EXP_TOP;
            end else begin
              w_man <= w_man >> 1;
              w_exp <= w_exp + EXP_ONE;
            end
          end else if (!w_man[MW-1]) begin
            if (w_exp > EXP_ONE) begin
              w_man <= w_man << 1;
              w_exp <= w_exp - EXP_ONE;
            end else begin
              w_man <= '0;
              w_exp <= '0;
            end
          end
        end
        PACK: result <= {w_sgn, w_exp, w_man[MAN_W-1:0]};
        default: ;
      endcase
    end
  end

endmodule
